// File: rtl/mskand_pkg.sv
// Shared helpers for the HPC2 masked AND-XOR gadget: randomness sizing,
// pair-to-randomness-bit mapping and share/lane bit positioning.
package mskand_pkg;

  function automatic int hpc2rnd(input int n_sh);
    return (n_sh * (n_sh - 1)) / 2;
  endfunction

  // Randomness bit for the unordered share pair {i,j}; symmetric in i and j.
  function automatic int idx(input int i, input int j, input int n_sh);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * n_sh - (lo * (lo + 1)) / 2 + (hi - 1 - lo);
  endfunction

  // Maps compact peer index j2 (0..n_sh-2) of share i back to a share number.
  function automatic int peer(input int i, input int j2);
    return (j2 < i) ? j2 : j2 + 1;
  endfunction

  function automatic int share_bit(input int share, input int lane, input int n_lane);
    return share * n_lane + lane;
  endfunction

endpackage

// File: rtl/mskand_hpc2_lane.sv
// One bit lane of the HPC2 AND-XOR gadget: two register stages per share pair,
// recombined combinationally from registered terms only.
module mskand_hpc2_lane
  import mskand_pkg::*;
#(
  parameter int d     = 2,
  parameter int XOR_C = 1,
  localparam int R    = hpc2rnd(d)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [d-1:0] i_b,
  input  logic [d-1:0] i_a,
  input  logic [d-1:0] i_c,
  input  logic [R-1:0] i_rnd,
  output logic [d-1:0] o_out
);

  localparam int M = d - 1;

  logic [d-1:0][M-1:0] r_v;
  logic [d-1:0][M-1:0] r_u;
  logic [d-1:0][M-1:0] r_w;
  logic [d-1:0][M-1:0] w_v_next;
  logic [d-1:0][M-1:0] w_u_next;
  logic [d-1:0][M-1:0] w_w_next;
  logic [d-1:0]        r_bprev;
  logic [R-1:0]        r_rprev;
  logic [d-1:0]        w_c;

  assign w_c = (XOR_C != 0) ? i_c : '0;

  for (genvar gi = 0; gi < d; gi++) begin : g_share
    for (genvar gj = 0; gj < M; gj++) begin : g_peer
      localparam int J = peer(gi, gj);
      localparam int P = idx(gi, J, d);
      assign w_v_next[gi][gj] = i_b[J] ^ i_rnd[P];
      assign w_w_next[gi][gj] = i_a[gi] & r_v[gi][gj];
      // The first peer slot also carries the in-domain product and c share.
      if (gj == 0) begin : g_first
        assign w_u_next[gi][gj] = (~i_a[gi] & r_rprev[P]) ^ (i_a[gi] & r_bprev[gi]) ^ w_c[gi];
      end else begin : g_rest
        assign w_u_next[gi][gj] = ~i_a[gi] & r_rprev[P];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v     <= '0;
      r_u     <= '0;
      r_w     <= '0;
      r_bprev <= '0;
      r_rprev <= '0;
    end else if (en) begin
      r_v     <= w_v_next;
      r_u     <= w_u_next;
      r_w     <= w_w_next;
      r_bprev <= i_b;
      r_rprev <= i_rnd;
    end
  end

  // u_ij and w_ij are never both set (gated by ~a_i / a_i), so OR equals XOR.
  always_comb begin
    o_out = '0;
    for (int i = 0; i < d; i++) begin
      o_out[i] = r_u[i][0] ^ r_w[i][0];
      for (int j = 1; j < M; j++) begin
        o_out[i] = o_out[i] ^ (r_u[i][j] | r_w[i][j]);
      end
    end
  end

endmodule

// File: rtl/mskand_hpc2_pipe.sv
// W-lane, d-share HPC2 masked AND-XOR pipeline with enable and valid tracking;
// out = (a & b) ^ c per lane, latency two enabled cycles from inb.
module mskand_hpc2_pipe
  import mskand_pkg::*;
#(
  parameter int d     = 2,
  parameter int W     = 8,
  parameter int XOR_C = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic [d*W-1:0]          inb,
  input  logic [W*hpc2rnd(d)-1:0] rnd,
  input  logic [d*W-1:0]          ina,
  input  logic [d*W-1:0]          inc,
  output logic [d*W-1:0]          out,
  output logic                    out_valid
);

  localparam int R = hpc2rnd(d);

  logic r_vld1;
  logic r_vld2;

  for (genvar gk = 0; gk < W; gk++) begin : g_lane
    logic [d-1:0] w_a;
    logic [d-1:0] w_b;
    logic [d-1:0] w_c;
    logic [d-1:0] w_o;

    // Gather share gi of lane gk from the share-major bus layout.
    for (genvar gi = 0; gi < d; gi++) begin : g_bits
      assign w_a[gi] = ina[share_bit(gi, gk, W)];
      assign w_b[gi] = inb[share_bit(gi, gk, W)];
      assign w_c[gi] = inc[share_bit(gi, gk, W)];
      assign out[share_bit(gi, gk, W)] = w_o[gi];
    end

    mskand_hpc2_lane #(
      .d     (d),
      .XOR_C (XOR_C)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .i_b   (w_b),
      .i_a   (w_a),
      .i_c   (w_c),
      .i_rnd (rnd[gk*R +: R]),
      .o_out (w_o)
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld1 <= 1'b0;
      r_vld2 <= 1'b0;
    end else if (en) begin
      r_vld1 <= in_valid;
      r_vld2 <= r_vld1;
    end
  end

  assign out_valid = r_vld2;

endmodule

// File: tb/tb_mskand_hpc2_pipe.sv
// Bench for mskand_hpc2_pipe: a d=3/XOR_C=1 and a d=2/XOR_C=0 instance checked
// every cycle against a closed-form per-share model, plus directed scenarios.
module tb_mskand_hpc2_pipe;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        in_valid;
  logic [11:0] inb3, ina3, inc3, rnd3, out3;
  logic        ov3;
  logic [7:0]  inb2, ina2, inc2, out2;
  logic [3:0]  rnd2;
  logic        ov2;

  int n_cmp = 0;
  int n_bad = 0;

  mskand_hpc2_pipe #(.d(3), .W(4), .XOR_C(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid),
    .inb(inb3), .rnd(rnd3), .ina(ina3), .inc(inc3),
    .out(out3), .out_valid(ov3)
  );

  mskand_hpc2_pipe #(.d(2), .W(4), .XOR_C(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid),
    .inb(inb2), .rnd(rnd2), .ina(ina2), .inc(inc2),
    .out(out2), .out_valid(ov2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int pidx(input int i, input int j, input int dd);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * dd - (lo * (lo + 1)) / 2 + (hi - 1 - lo);
  endfunction

  // Closed form of each output share: out_i = a_i*b_i ^ c_i ^ XOR_{j!=i}(a_i*b_j ^ r_ij).
  function automatic logic [11:0] exp_out(input int dd, input bit xc, input logic [11:0] a,
                                          input logic [11:0] b, input logic [11:0] c,
                                          input logic [11:0] r);
    logic [11:0] o;
    int rr;
    o  = '0;
    rr = dd * (dd - 1) / 2;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < dd; i++) begin
        logic s;
        s = (a[i*4+k] & b[i*4+k]) ^ (xc & c[i*4+k]);
        for (int j = 0; j < dd; j++) begin
          if (j != i) s = s ^ (a[i*4+k] & b[j*4+k]) ^ r[k*rr + pidx(i, j, dd)];
        end
        o[i*4+k] = s;
      end
    end
    return o;
  endfunction

  function automatic logic [3:0] recomb(input int dd, input logic [11:0] v);
    logic [3:0] x;
    x = '0;
    for (int i = 0; i < dd; i++) x = x ^ v[i*4 +: 4];
    return x;
  endfunction

  task automatic rand_all();
    inb3 = 12'($urandom);
    ina3 = 12'($urandom);
    inc3 = 12'($urandom);
    rnd3 = 12'($urandom);
    inb2 = 8'($urandom);
    ina2 = 8'($urandom);
    inc2 = 8'($urandom);
    rnd2 = 4'($urandom);
  endtask

  // Model state: operands captured at the inb edge and the visible output slot.
  logic [11:0] m3_b, m3_r, m3_o, m2_b, m2_r, m2_o;
  logic        m3_v1, m3_v2, m2_v1, m2_v2;

  initial begin
    m3_b = '0; m3_r = '0; m3_o = '0; m3_v1 = 1'b0; m3_v2 = 1'b0;
    m2_b = '0; m2_r = '0; m2_o = '0; m2_v1 = 1'b0; m2_v2 = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        m3_b = '0; m3_r = '0; m3_o = '0; m3_v1 = 1'b0; m3_v2 = 1'b0;
        m2_b = '0; m2_r = '0; m2_o = '0; m2_v1 = 1'b0; m2_v2 = 1'b0;
      end else if (en) begin
        m3_o  = exp_out(3, 1'b1, ina3, m3_b, inc3, m3_r);
        m3_v2 = m3_v1;
        m3_b  = inb3;
        m3_r  = rnd3;
        m3_v1 = in_valid;
        m2_o  = exp_out(2, 1'b0, {4'h0, ina2}, m2_b, {4'h0, inc2}, m2_r);
        m2_v2 = m2_v1;
        m2_b  = {4'h0, inb2};
        m2_r  = {8'h0, rnd2};
        m2_v1 = in_valid;
      end
      chk("out_d3", out3, m3_o);
      chk("valid_d3", {11'h0, ov3}, {11'h0, m3_v2});
      chk("out_d2", {4'h0, out2}, m2_o);
      chk("valid_d2", {11'h0, ov2}, {11'h0, m2_v2});
    end
  end

  logic [3:0] s_b, s_a, s_c;

  initial begin
    rst_n = 1'b1; en = 1'b0; in_valid = 1'b0;
    inb3 = '0; ina3 = '0; inc3 = '0; rnd3 = '0;
    inb2 = '0; ina2 = '0; inc2 = '0; rnd2 = '0;
    s_b = '0; s_a = '0; s_c = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_out", out3, 12'h000);
    chk("reset_valid", {11'h0, ov3}, 12'h000);
    chk("model_pin_and_xor", {8'h0, recomb(3, exp_out(3, 1'b1, 12'h00C, 12'h00A, 12'h003, 12'($urandom)))}, 12'h00B);
    chk("model_pin_no_c", {8'h0, recomb(2, exp_out(2, 1'b0, 12'h000, 12'h00F, 12'h0FF, 12'($urandom)))}, 12'h000);
    rst_n = 1'b1; en = 1'b1;

    // Directed: b=0xA, then a=0xC, c=0x3 with zero randomness.
    @(negedge clk);
    rand_all();
    in_valid = 1'b1; inb3 = 12'h00A; rnd3 = '0; inb2 = 8'h0F; rnd2 = '0;
    @(negedge clk);
    rand_all();
    in_valid = 1'b0; ina3 = 12'h00C; inc3 = 12'h003; ina2 = 8'h00; inc2 = 8'hFF;
    @(negedge clk);
    chk("directed_recomb", {8'h0, recomb(3, out3)}, 12'h00B);
    chk("directed_valid", {11'h0, ov3}, 12'h001);
    chk("noc_recomb", {8'h0, recomb(2, {4'h0, out2})}, 12'h000);
    chk("noc_valid", {11'h0, ov2}, 12'h001);
    rand_all();
    @(negedge clk);
    chk("directed_single_pulse", {11'h0, ov3}, 12'h000);

    // Back-to-back random tokens.
    repeat (4000) begin
      @(negedge clk);
      rand_all();
      en = 1'b1;
      in_valid = ($urandom_range(0, 3) != 0);
    end

    // Random tokens with random stalls.
    repeat (2000) begin
      @(negedge clk);
      rand_all();
      en = ($urandom_range(0, 3) != 0);
      in_valid = $urandom_range(0, 1) != 0;
    end

    // Stall: token at t0, en low t1..t4, a/c at t5, result at t6.
    @(negedge clk);
    rand_all(); en = 1'b1; in_valid = 1'b1; s_b = recomb(3, inb3);
    repeat (4) begin
      @(negedge clk);
      rand_all(); en = 1'b0; in_valid = 1'b1;
    end
    @(negedge clk);
    rand_all(); en = 1'b1; in_valid = 1'b0;
    s_a = recomb(3, ina3); s_c = recomb(3, inc3);
    @(negedge clk);
    chk("stall_valid", {11'h0, ov3}, 12'h001);
    chk("stall_recomb", {8'h0, recomb(3, out3)}, {8'h0, (s_a & s_b) ^ s_c});

    // Reset mid-flight.
    rand_all(); in_valid = 1'b1;
    @(negedge clk);
    rand_all(); in_valid = 1'b1;
    @(negedge clk);
    rand_all(); in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_out3", out3, 12'h000);
    chk("async_reset_valid3", {11'h0, ov3}, 12'h000);
    chk("async_reset_out2", {4'h0, out2}, 12'h000);
    chk("async_reset_valid2", {11'h0, ov2}, 12'h000);
    @(negedge clk);
    rst_n = 1'b1; rand_all(); in_valid = 1'b1;
    @(negedge clk);
    rand_all(); in_valid = 1'b0;
    @(negedge clk);
    chk("post_reset_new_token", {11'h0, ov3}, 12'h001);

    // Lane isolation: only lane-3 randomness varies.
    rand_all(); in_valid = 1'b1;
    repeat (50) begin
      @(negedge clk);
      rnd3[11:9] = 3'($urandom);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mskand_hpc2_pipe.md
Name: mskand_hpc2_pipe

Overview:
- W-lane, d-share HPC2 masked AND-XOR gadget computing out = (a & b) ^ c per lane. It runs two stages with a pipeline-enable and a valid-tracking token.
- Successor to the single-bit 2nd-order Toffoli gadget. Generalised in share count d, lane count W and mode (plain AND or AND-XOR).
- Adds stall support, registered-randomness alignment under stall, and valid tracking.
- Used as the bulk nonlinear layer in wider S-box datapaths.

Parameters:
- d, 2, number of shares (≥2).
- W, 8, number of independent bit lanes.
- XOR_C, 1, 1: out = a&b ^ c; 0: out = a&b and inc is ignored (tie-off permitted).

Ports:
- clk  in  1  clock; all registers rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  pipeline enable; when low, every register holds.
- in_valid  in  1  qualifies inb this cycle (token enters stage 1).
- inb  in  d*W  sharing of b, latency 0; bit i*W+k is share i of lane k.
- rnd  in  W*R  fresh randomness, latency 0, R = d(d-1)/2 per lane; lane k uses rnd[k*R +: R].
- ina  in  d*W  sharing of a, latency 1 (presented one enabled cycle after inb).
- inc  in  d*W  sharing of c, latency 1.
- out  out  d*W  result sharing, latency 2.
- out_valid  out  1  out carries a result.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All internal registers (v, u, w, rnd_prev, valid pipe) clear to 0.
  - out = 0, out_valid = 0.
  - Release is synchronous to clk via the standard reset synchroniser outside the block.
- Randomness index:
  - For lane k, pair (i<j), index p = i*d − i(i+1)/2 + (j−1−i).
  - r_ij = r_ji = rnd[k*R+p]. Diagonal is unused.
- Stage 1 (at enabled edge t):
  - v_ij ← b_j ^ r_ij for all i≠j.
  - rnd_prev ← rnd.
  - vld1 ← in_valid.
- Stage 1' (at enabled edge t+1, ina/inc valid). Let j2 be the compact index of j≠i.
  - j2=0: u_ij ← (~a_i & rprev_ij) ^ (a_i & b_prev_i) ^ (XOR_C ? c_i : 0).
    - b_prev_i is share i of inb registered at edge t.
  - j2≠0: u_ij ← ~a_i & rprev_ij.
  - w_ij ← a_i & v_ij.
  - vld2 ← vld1.
- Output (combinational from stage-2 registers):
  - out_i = u_i0 ^ w_i0 ^ ⊕_{j2≠0}(u_ij | w_ij).
  - OR is legal because its operands are mutually exclusive.
  - out_valid = vld2.
- Latency: exactly 2 enabled cycles from inb/in_valid to out/out_valid.
- Fully pipelined: a new token is accepted every enabled cycle.
- Stall (en=0): all registers hold, including rnd_prev and the b-share register. out and out_valid are stable. rnd, inb, ina and inc are ignored during stall. The ina/inc sampling point is the next enabled cycle after the inb cycle, not the next clock.
- The randomness consumer must present fresh rnd on each enabled cycle with in_valid. Reuse of rnd across tokens is a caller bug, not detected.
- in_valid=0 on an enabled cycle: the data path still advances (garbage shares), and out_valid=0 for that slot.
- Reset mid-operation: in-flight tokens are discarded. No out_valid pulse appears after reset for tokens accepted before it.
- Security:
  - Share domains stay separate. No combinational path from inb or rnd to out.
  - Every cross-domain term passes through a register before recombination.
  - Lanes share no randomness.

Decomposition:
- Package mskand_pkg:
  - function hpc2rnd(d) = d(d-1)/2.
  - pair-index function idx(i,j,d).
  - local constants for share/lane bit positioning.
- Sub-module mskand_hpc2_lane (one bit lane, parameter d, XOR_C, with en/rst_n).
  - Instantiated W times by generate.
  - The valid pipe lives in the top.
- Registers use the existing bin_REG cell, extended with enable and async reset.

Test Plan:
- d=2, W=4, XOR_C=1, rnd=0, en=1:
  - Stimulus: at t0 send b=0xA; at t1 send a=0xC, c=0x3 (unshared values, share1=0).
  - Required: at t2 out recombines to (0xC&0xA)^0x3 = 0xB, and out_valid=1 only at t2.
- Random shares and random rnd (d=2, d=3), 10k back-to-back tokens, XOR_C=0 and 1: the recombined out matches the golden model every cycle, and out_valid follows in_valid delayed by 2.
- Stall: token accepted at t0, en low at t1..t4, ina presented at t5.
  - Required: out valid at t6 with the correct value.
  - rnd changes during stall have no effect. out/out_valid are held during stall.
- Reset mid-flight: in_valid at t0, rst_n asserted at t1.
  - Required: out=0 and out_valid=0 immediately (asynchronously).
  - No valid at t2. After release, a new token completes in 2 cycles.
- Lane isolation: vary only lane-3 rnd bits while inputs are fixed; other lanes' out shares stay bit-identical.
- XOR_C=0: inc=all-ones with a=0x0, b=0xF → recombined out=0x0.
